// File: rtl/dtw_pkg.sv
// Shared DTW constants: result frame layout and collector state encoding.
package dtw_pkg;

  localparam int unsigned DTW_WIDTH = 16;
  localparam int unsigned RES_WORDS = 3;

  localparam logic [1:0] W_QID = 2'd0;
  localparam logic [1:0] W_POS = 2'd1;
  localparam logic [1:0] W_MIN = 2'd2;

  typedef enum logic [0:0] {
    StCollect,
    StEmit
  } state_e;

endpackage

// File: rtl/dtw_result_collector_if.sv
// Valid/ready result record port of the DTW result collector (host/DMA side).
interface dtw_result_collector_if #(
  parameter int unsigned WIDTH = dtw_pkg::DTW_WIDTH
);
  logic             valid;
  logic             ready;
  logic [31:0]      qid;
  logic [31:0]      pos;
  logic [WIDTH-1:0] minval;
  logic             hit;

  modport master (
    output valid,
    output qid,
    output pos,
    output minval,
    output hit,
    input  ready
  );

  modport slave (
    input  valid,
    input  qid,
    input  pos,
    input  minval,
    input  hit,
    output ready
  );
endinterface

// File: rtl/dtw_result_collector.sv
// Pops 3-word DTW result frames from the sink FIFO and presents them as one record.
// Optional hit filter enabled by defining DTW_RESULT_THRESH_EN.
module dtw_result_collector
  import dtw_pkg::*;
#(
  parameter int unsigned WIDTH     = DTW_WIDTH,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  output logic                   fifo_rden,
  input  logic                   fifo_empty,
  input  logic [31:0]            fifo_data,
  dtw_result_collector_if.master res,
  input  logic [WIDTH-1:0]       thresh,
  output logic [CNT_WIDTH-1:0]   n_results,
  output logic [CNT_WIDTH-1:0]   n_dropped,
  output logic                   frame_err
);

  state_e               state_q;
  logic [1:0]           issued_q;
  logic [1:0]           captured_q;
  logic                 pending_q;
  logic [31:0]          qid_q;
  logic [31:0]          pos_q;
  logic [WIDTH-1:0]     minval_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] n_results_q;
  logic [CNT_WIDTH-1:0] n_dropped_q;
  logic                 frame_err_q;
  logic [WIDTH-1:0]     word_min;
  logic                 keep;

  assign word_min = fifo_data[WIDTH-1:0];

`ifdef DTW_RESULT_THRESH_EN
  logic hit_q;
  assign keep    = (word_min <= thresh);
  assign res.hit = hit_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign keep          = 1'b1;
  assign res.hit       = 1'b1;
`endif

  // No reads are issued while a record waits in EMIT, so frames never overlap.
  assign fifo_rden = (state_q == StCollect) && !fifo_empty &&
                     (issued_q < 2'(RES_WORDS)) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      state_q     <= StCollect;
      issued_q    <= '0;
      captured_q  <= '0;
      pending_q   <= 1'b0;
      qid_q       <= '0;
      pos_q       <= '0;
      minval_q    <= '0;
      valid_q     <= 1'b0;
      n_results_q <= '0;
      n_dropped_q <= '0;
      frame_err_q <= 1'b0;
`ifdef DTW_RESULT_THRESH_EN
      hit_q       <= 1'b0;
`endif
    end else begin
      pending_q <= fifo_rden;
      if (fifo_rden) issued_q <= issued_q + 2'd1;

      if (pending_q) begin
        if (captured_q == W_QID) qid_q <= fifo_data;
        if (captured_q == W_POS) pos_q <= fifo_data;
        if (captured_q == W_MIN) begin
          issued_q   <= '0;
          captured_q <= '0;
          if (fifo_data[31:WIDTH] != '0) frame_err_q <= 1'b1;
          if (keep) begin
            minval_q <= word_min;
            valid_q  <= 1'b1;
            state_q  <= StEmit;
`ifdef DTW_RESULT_THRESH_EN
            hit_q    <= 1'b1;
`endif
          end else begin
            n_dropped_q <= n_dropped_q + 1'b1;
          end
        end else begin
          captured_q <= captured_q + 2'd1;
        end
      end

      if (state_q == StEmit && res.ready) begin
        valid_q     <= 1'b0;
        state_q     <= StCollect;
        n_results_q <= n_results_q + 1'b1;
      end
    end
  end

  assign res.valid  = valid_q;
  assign res.qid    = qid_q;
  assign res.pos    = pos_q;
  assign res.minval = minval_q;
  assign n_results  = n_results_q;
  assign n_dropped  = n_dropped_q;
  assign frame_err  = frame_err_q;

endmodule
